// File: rtl/melody_pkg.sv
// melody_pkg: state encoding, note-entry layout and marker constants shared by
// the melody sequencer and its note table.
package melody_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PLAY
  } state_t;

  localparam int END_MARK = 0;  // beat value that terminates a song
  localparam int REST     = 0;  // half-period value that plays silence

  localparam int BEAT_W_DEF = 32;
  localparam int HP_W_DEF   = 20;

  // Default-width entry layout; the sequencer declares the same layout at its
  // own parameter widths.
  typedef struct packed {
    logic [BEAT_W_DEF-1:0] beat;
    logic [HP_W_DEF-1:0]   half_period;
  } note_t;

endpackage

// File: rtl/melody_note_table.sv
// melody_note_table: DEPTH-entry note store, one write port and one registered
// read port so it maps onto a block RAM.
module melody_note_table #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 52
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: no reset on the array; a reset would stop it inferring a block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a run-time loaded note table as a square wave into
// the audio controller. Define MELODY_SEQ_ARTIC_EN to silence the tail of each note.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int BEAT_W     = 32,
  parameter int HP_W       = 20,
  parameter int SAMPLE_W   = 32,
  parameter int AMP        = 100000000,
  parameter int GAP_CYCLES = 500000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [BEAT_W-1:0]        wr_beat,
  input  logic [HP_W-1:0]          wr_half_period,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [SAMPLE_W-1:0]      left_sample,
  output logic [SAMPLE_W-1:0]      right_sample,
  output logic                     playing,
  output logic [$clog2(DEPTH)-1:0] note_idx,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [SAMPLE_W-1:0] POS_AMP = SAMPLE_W'(AMP);
  localparam logic [SAMPLE_W-1:0] NEG_AMP = -POS_AMP;

  typedef struct packed {
    logic [BEAT_W-1:0] beat;
    logic [HP_W-1:0]   half_period;
  } entry_t;

  state_t            state;
  logic              fetch_phase;  // 0: address presented, 1: data valid
  logic [AW-1:0]     idx;
  logic [BEAT_W-1:0] beat;
  logic [HP_W-1:0]   hp;
  logic [BEAT_W-1:0] bcnt;
  logic [HP_W-1:0]   fcnt;
  logic              sign;
  logic              flush;
  logic              gap;
  logic              capture;
  entry_t            wr_entry;
  entry_t            rd_entry;
  logic [SAMPLE_W-1:0] sample_next;

  assign wr_entry = '{beat: wr_beat, half_period: wr_half_period};
  assign capture  = (state == FETCH) && fetch_phase && !stop;

  melody_note_table #(
    .DEPTH(DEPTH),
    .WIDTH(BEAT_W + HP_W)
  ) u_table (
    .clk    (CLOCK_50),
    .wr_en  (wr_en && (state == IDLE)),
    .wr_addr(wr_addr),
    .wr_data(wr_entry),
    .rd_addr(idx),
    .rd_data(rd_entry)
  );

`ifdef MELODY_SEQ_ARTIC_EN
  logic [BEAT_W-1:0] gap_start;

  function automatic logic [BEAT_W-1:0] gap_len(input logic [BEAT_W-1:0] b);
    logic [BEAT_W-1:0] quarter;
    quarter = b >> 2;
    if (64'(GAP_CYCLES) < 64'(quarter)) return BEAT_W'(GAP_CYCLES);
    return quarter;
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (reset)        gap_start <= '0;
    else if (capture) gap_start <= rd_entry.beat - gap_len(rd_entry.beat);
  end

  assign gap = (bcnt >= gap_start);
`else
  localparam int gap_cycles_unused = GAP_CYCLES;
  assign gap = 1'b0;
`endif

  // NOTE: default first so every path assigns the output and no latch forms.
  always_comb begin
    sample_next = '0;
    if (state == PLAY && !stop && hp != HP_W'(REST) && !gap)
      sample_next = sign ? NEG_AMP : POS_AMP;
  end

  // NOTE: all state below uses <= so every register sees pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      fetch_phase <= 1'b0;
      idx         <= '0;
      beat        <= '0;
      hp          <= '0;
      bcnt        <= '0;
      fcnt        <= '0;
      sign        <= 1'b0;
      flush       <= 1'b0;
      left_sample <= '0;
      out_valid   <= 1'b0;
      playing     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      flush       <= 1'b0;
      left_sample <= sample_next;
      // One trailing write after an abort flushes a zero sample to the FIFO.
      out_valid   <= out_ready && (playing || flush);

      if (stop && state != IDLE) begin
        state       <= IDLE;
        fetch_phase <= 1'b0;
        playing     <= 1'b0;
        flush       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              idx         <= '0;
              fetch_phase <= 1'b0;
              state       <= FETCH;
              playing     <= 1'b1;
            end
          end

          FETCH: begin
            if (!fetch_phase) begin
              fetch_phase <= 1'b1;
            end else begin
              fetch_phase <= 1'b0;
              beat        <= rd_entry.beat;
              hp          <= rd_entry.half_period;
              bcnt        <= '0;
              fcnt        <= '0;
              sign        <= 1'b0;
              if (rd_entry.beat != BEAT_W'(END_MARK)) begin
                state <= PLAY;
              end else if (loop_en) begin
                idx <= '0;  // an empty song spins here until stop
              end else begin
                state   <= IDLE;
                playing <= 1'b0;
                done    <= 1'b1;
              end
            end
          end

          PLAY: begin
            bcnt <= bcnt + BEAT_W'(1);
            if (fcnt == hp - HP_W'(1)) begin
              fcnt <= '0;
              sign <= ~sign;
            end else begin
              fcnt <= fcnt + HP_W'(1);
            end

            if (bcnt == beat - BEAT_W'(1)) begin
              fetch_phase <= 1'b0;
              if (idx != AW'(DEPTH - 1)) begin
                idx   <= idx + AW'(1);
                state <= FETCH;
              end else if (loop_en) begin
                idx   <= '0;
                state <= FETCH;
              end else begin
                state   <= IDLE;
                playing <= 1'b0;
                done    <= 1'b1;
              end
            end
          end

          default: begin
            state   <= IDLE;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign right_sample = left_sample;
  assign note_idx     = idx;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: table-driven per-cycle vectors plus hand-written
// sequences for looping, full-table and reset corner cases.
module tb_melody_sequencer;

  localparam int DEPTH    = 4;
  localparam int BEAT_W   = 8;
  localparam int HP_W     = 4;
  localparam int SAMPLE_W = 16;
  localparam int AMP      = 1000;
  localparam logic [SAMPLE_W-1:0] POS = 16'd1000;
  localparam logic [SAMPLE_W-1:0] NEG = 16'hFC18;

  logic                clk;
  logic                reset;
  logic                wr_en;
  logic [1:0]          wr_addr;
  logic [BEAT_W-1:0]   wr_beat;
  logic [HP_W-1:0]     wr_half_period;
  logic                start;
  logic                stop;
  logic                loop_en;
  logic                out_ready;
  logic                out_valid;
  logic [SAMPLE_W-1:0] left_sample;
  logic [SAMPLE_W-1:0] right_sample;
  logic                playing;
  logic [1:0]          note_idx;
  logic                done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          start;
    logic          stop;
    logic          loop_en;
    logic          out_ready;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [7:0]    wr_beat;
    logic [3:0]    wr_hp;
    logic [15:0]   sample;
    logic          playing;
    logic [1:0]    idx;
    logic          done;
    logic          valid;
  } vec_t;

  vec_t vecs[$];

  melody_sequencer #(
    .DEPTH   (DEPTH),
    .BEAT_W  (BEAT_W),
    .HP_W    (HP_W),
    .SAMPLE_W(SAMPLE_W),
    .AMP     (AMP)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_beat       (wr_beat),
    .wr_half_period(wr_half_period),
    .start         (start),
    .stop          (stop),
    .loop_en       (loop_en),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .left_sample   (left_sample),
    .right_sample  (right_sample),
    .playing       (playing),
    .note_idx      (note_idx),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_note(input logic [1:0] a, input logic [7:0] b, input logic [3:0] h);
    wr_en = 1'b1; wr_addr = a; wr_beat = b; wr_half_period = h;
    step();
    wr_en = 1'b0;
  endtask

  task automatic load_song1();
    write_note(2'd0, 8'd8, 4'd2);
    write_note(2'd1, 8'd8, 4'd0);
    write_note(2'd2, 8'd0, 4'd0);
    write_note(2'd3, 8'd0, 4'd0);
  endtask

  // Song 1: {8,2},{8,0},{0,0}, one-shot. Row k is observed just after edge k.
  task automatic fill_song1(input bit toggle_ready, input bit inject_write);
    vec_t v;
    vecs.delete();
    for (int k = 1; k <= 24; k++) begin
      v = '{default: '0};
      v.start     = (k == 1);
      v.out_ready = toggle_ready ? k[0] : 1'b1;
      v.wr_en     = inject_write && (k == 5);
      v.wr_addr   = 2'd1;
      v.wr_beat   = 8'd4;
      v.wr_hp     = 4'd1;
      v.playing   = (k <= 22);
      v.idx       = (k <= 10) ? 2'd0 : (k <= 20) ? 2'd1 : 2'd2;
      v.done      = (k == 23);
      v.valid     = v.out_ready && (k >= 2) && (k <= 23);
      v.sample    = (k >= 4 && k <= 11) ? (((k - 4) % 4 < 2) ? POS : NEG) : 16'd0;
      vecs.push_back(v);
    end
  endtask

  // Stop and start together during PLAY cycle bcnt=5 of note 0.
  task automatic fill_stop();
    vec_t v;
    vecs.delete();
    for (int k = 1; k <= 14; k++) begin
      v = '{default: '0};
      v.start     = (k == 1) || (k == 9);
      v.stop      = (k == 9);
      v.out_ready = 1'b1;
      v.playing   = (k <= 8);
      v.idx       = 2'd0;
      v.valid     = (k >= 2) && (k <= 10);
      v.sample    = (k >= 4 && k <= 8) ? (((k - 4) % 4 < 2) ? POS : NEG) : 16'd0;
      vecs.push_back(v);
    end
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      start = vecs[i].start; stop = vecs[i].stop; loop_en = vecs[i].loop_en;
      out_ready = vecs[i].out_ready; wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr;
      wr_beat = vecs[i].wr_beat; wr_half_period = vecs[i].wr_hp;
      step();
      check($sformatf("%s[%0d].left", tag, i + 1), left_sample, vecs[i].sample);
      check($sformatf("%s[%0d].right", tag, i + 1), right_sample, vecs[i].sample);
      check($sformatf("%s[%0d].playing", tag, i + 1), playing, vecs[i].playing);
      check($sformatf("%s[%0d].idx", tag, i + 1), note_idx, vecs[i].idx);
      check($sformatf("%s[%0d].done", tag, i + 1), done, vecs[i].done);
      check($sformatf("%s[%0d].valid", tag, i + 1), out_valid, vecs[i].valid);
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_loop();
    int exp_cyc[9] = '{11, 21, 23, 33, 43, 45, 55, 65, 67};
    int exp_idx[9] = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
    int got_cyc[$];
    int got_idx[$];
    int done_cnt = 0;
    logic [1:0] prev;
    loop_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    prev = note_idx;
    for (int c = 2; c <= 70; c++) begin
      step();
      if (done) done_cnt++;
      if (note_idx != prev) begin
        got_cyc.push_back(c);
        got_idx.push_back(int'(note_idx));
        prev = note_idx;
      end
    end
    check("loop.done_count", done_cnt, 0);
    check("loop.idx_changes", got_cyc.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < got_cyc.size()) begin
        check($sformatf("loop.change%0d.cycle", i), got_cyc[i], exp_cyc[i]);
        check($sformatf("loop.change%0d.idx", i), got_idx[i], exp_idx[i]);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0; loop_en = 1'b0;
    check("loop.stop_playing", playing, 1'b0);
    check("loop.stop_done", done, 1'b0);
    step();
  endtask

  task automatic test_full_table();
    int done_cnt = 0;
    int done_cyc = -1;
    write_note(2'd0, 8'd3, 4'd1);
    write_note(2'd1, 8'd2, 4'd1);
    write_note(2'd2, 8'd4, 4'd2);
    write_note(2'd3, 8'd2, 4'd0);
    loop_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 40; c++) begin
      step();
      if (c == 4) check("full.sample_c4", left_sample, POS);
      if (c == 5) check("full.sample_c5", left_sample, NEG);
      if (c == 6) check("full.sample_c6", left_sample, POS);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    check("full.done_count", done_cnt, 1);
    check("full.done_cycle", done_cyc, 20);
    check("full.final_idx", note_idx, 2'd3);
    check("full.final_playing", playing, 1'b0);
  endtask

  task automatic test_reset_mid_play();
    loop_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 6; c++) step();
    check("rst.before_sample", left_sample, NEG);
    check("rst.before_playing", playing, 1'b1);
    reset = 1'b1;
    step();
    check("rst.left", left_sample, 16'd0);
    check("rst.right", right_sample, 16'd0);
    check("rst.playing", playing, 1'b0);
    check("rst.idx", note_idx, 2'd0);
    check("rst.done", done, 1'b0);
    check("rst.valid", out_valid, 1'b0);
    reset = 1'b0;
    step();
  endtask

  task automatic test_empty_loop();
    int done_cnt = 0;
    write_note(2'd0, 8'd0, 4'd0);
    loop_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      step();
      if (done) done_cnt++;
    end
    check("empty.done_count", done_cnt, 0);
    check("empty.playing", playing, 1'b1);
    check("empty.idx", note_idx, 2'd0);
    check("empty.sample", left_sample, 16'd0);
    stop = 1'b1;
    step();
    stop = 1'b0; loop_en = 1'b0;
    check("empty.stop_playing", playing, 1'b0);
    check("empty.stop_done", done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_beat = '0; wr_half_period = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check("reset.left", left_sample, 16'd0);
    check("reset.playing", playing, 1'b0);
    check("reset.idx", note_idx, 2'd0);
    check("reset.done", done, 1'b0);
    check("reset.valid", out_valid, 1'b0);
    reset = 1'b0;
    step();

    load_song1();
    fill_song1(1'b0, 1'b0);
    run_vecs("oneshot");
    step();

    test_loop();
    test_full_table();
    step();

    load_song1();
    fill_stop();
    run_vecs("stop");

    fill_song1(1'b1, 1'b0);
    run_vecs("ready_toggle");
    step();

    fill_song1(1'b0, 1'b1);
    run_vecs("write_in_play");
    step();

    test_reset_mid_play();
    test_empty_loop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Parametrised, table-driven square-wave melody player. It succeeds the hard-coded beat/tone case statement in the audio top level. Notes (duration, half-period) are loaded into an internal note table at run time, then played back as signed PCM samples to the Audio_Controller write port. Supports one-shot/loop mode, rests, end-of-song markers, start/stop control and a done pulse.

Parameters:
DEPTH, 32, note table entries (power of 2, >=2)
BEAT_W, 32, width of note duration field (CLOCK_50 cycles)
HP_W, 20, width of half-period field (CLOCK_50 cycles)
SAMPLE_W, 32, output sample width
AMP, 100000000, positive peak amplitude (must fit SAMPLE_W-1 bits)
GAP_CYCLES, 500000, articulation gap length (used only with the optional feature)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  note table write strobe (honoured only in IDLE)
wr_addr  in  log2(DEPTH)  table write address
wr_beat  in  BEAT_W  note duration; 0 = end-of-song marker
wr_half_period  in  HP_W  tone half period; 0 = rest
start  in  1  one-cycle pulse: begin playback at entry 0
stop  in  1  level/pulse: abort playback, return to IDLE
loop_en  in  1  1 = restart at entry 0 at end of song
out_ready  in  1  Audio_Controller audio_out_allowed
out_valid  out  1  drives write_audio_out
left_sample  out  SAMPLE_W  left channel sample
right_sample  out  SAMPLE_W  right channel sample (identical to left)
playing  out  1  high in FETCH or PLAY
note_idx  out  log2(DEPTH)  index of the current note
done  out  1  one-cycle pulse at end of a one-shot song

Behaviour:
- Reset: state IDLE, idx=0, bcnt=fcnt=0, sign=0, samples=0, out_valid=0, playing=0, done=0. Table contents are not reset.
- States: IDLE, FETCH, PLAY.
- IDLE: wr_en writes {wr_beat, wr_half_period} to wr_addr. start -> idx=0, go to FETCH. Writes in FETCH/PLAY are ignored.
- FETCH: table read has 1-cycle latency, so FETCH lasts 2 cycles (address, then capture). On capture, latch beat/hp, clear bcnt/fcnt/sign.
  - beat!=0 -> PLAY.
  - beat==0 with loop_en=1 -> idx=0, re-enter FETCH.
  - beat==0 with loop_en=0 -> IDLE, pulse done.
  - If entry 0 itself has beat==0 and loop_en=1: hold in FETCH until stop (no lockup of control).
- PLAY, every cycle:
  - bcnt++.
  - When bcnt==beat-1: idx+1 -> FETCH.
  - idx==DEPTH-1 counts as end of song (loop/done rules as above).
  - fcnt++; when fcnt==hp-1: fcnt=0, toggle sign.
- Sample register, updated each cycle:
  - +AMP if sign=0, -AMP (two's complement, SAMPLE_W) if sign=1.
  - 0 when hp==0 or state!=PLAY.
  - Note-to-sample latency: first nonzero sample is 3 cycles after start.
- out_valid = out_ready registered-AND (playing | 1 cycle after stop). Silence is still written, so the controller FIFO never starves while active. Samples are never held for backpressure: tone generation is free-running and writes are simply skipped when out_ready=0.
- stop: next cycle IDLE, samples 0, done not pulsed. stop and start together: stop wins. start while playing: ignored.
- reset mid-playback: same as the reset values above.
- note_idx wraps modulo DEPTH. Counters are BEAT_W/HP_W unsigned and cannot overflow because they are compared against latched values.

Optional Feature:
MELODY_SEQ_ARTIC_EN
- Defined: the last min(GAP_CYCLES, beat/4) cycles of each non-rest note output 0, so repeated pitches are audibly separated. bcnt timing and note_idx are unchanged.
- Undefined: notes play full length and the GAP_CYCLES parameter is unused.

Decomposition:
- Package melody_pkg: note entry struct {beat, half_period}, state enum {IDLE, FETCH, PLAY}, constants END_MARK=0, REST=0.
- One sub-module, melody_note_table: DEPTH x (BEAT_W+HP_W) synchronous-read RAM (1 write port, 1 read port, M9K-inferable). All control stays in melody_sequencer.

Test Plan:
Bench parameters: DEPTH=4, BEAT_W=8, HP_W=4, SAMPLE_W=16, AMP=1000.
1. Load {8,2},{8,0},{0,0}; start, loop_en=0 -> left_sample = +1000,+1000,-1000,-1000 repeating for 8 cycles, then 8 cycles of 0, then done pulses once; playing falls.
2. Same table with loop_en=1 -> note_idx sequence 0,1,2,0,... with no done pulse over 3 loops.
3. Full table of 4 nonzero notes, loop_en=0 -> after idx 3, returns to IDLE with done; no read beyond DEPTH-1.
4. stop asserted mid-note (cycle 5 of note 0), start in the same cycle -> IDLE next cycle, samples 0, no done, playing=0.
5. out_ready toggled 1/0 every cycle -> out_valid follows out_ready one cycle later; note durations remain exactly 8 cycles.
6. wr_en during PLAY to idx 1 with {4,1} -> table unchanged (note 1 is still a rest of 8 cycles); synchronous reset mid-PLAY clears all outputs on the next edge.
